// File: rtl/seg7_pkg.sv
// Shared constants for the 4-digit multiplexed 7-segment driver.
// Segment patterns are active-low: bit 0 = a ... bit 6 = g.
package seg7_pkg;

    localparam int unsigned IDX_W    = 2;
    localparam logic [IDX_W-1:0] IDX_LAST = '1;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] AN_OFF    = 4'hF;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Digit inputs from the time-to-digits stage and the multiplexed display outputs.
// master = upstream/board side, slave = the scan driver.
interface seg7_scan_driver_if;

    logic [3:0] ones;
    logic [3:0] tens;
    logic [3:0] hundreds;
    logic [3:0] thousands;
    logic [3:0] blink_mask;
    logic [3:0] dp_mask;
    logic       blank_lz;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (
        output ones, tens, hundreds, thousands, blink_mask, dp_mask, blank_lz,
        input  an, seg, dp
    );

    modport slave (
        input  ones, tens, hundreds, thousands, blink_mask, dp_mask, blank_lz,
        output an, seg, dp
    );

endinterface

// File: rtl/seg7_decode.sv
// BCD to active-low 7-segment decoder; non-BCD codes render as blank.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// 4-digit common-anode scan driver with anti-ghost blanking, blink, dp and
// leading-zero blanking. Inputs are snapshotted once per frame.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 100000,
    parameter int unsigned BLANK_CYC = 2000,
    parameter int unsigned BLINK_DIV = 25000000
) (
    input  logic              clk,
    input  logic              reset,
    seg7_scan_driver_if.slave bus
);

    localparam int unsigned SlotW  = $clog2(SCAN_DIV);
    localparam int unsigned BlinkW = $clog2(BLINK_DIV);
    localparam logic [SlotW-1:0]  SlotLast  = SlotW'(SCAN_DIV - 1);
    localparam logic [SlotW-1:0]  BlankCnt  = SlotW'(BLANK_CYC);
    localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_DIV - 1);

    logic [SlotW-1:0]  r_slot_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic [BlinkW-1:0] r_blink_cnt;
    logic              r_blink_phase;

    logic [3:0][3:0]   r_digit_s;
    logic [3:0]        r_blink_s;
    logic [3:0]        r_dp_s;
    logic              r_blank_lz_s;

    logic [3:0]        r_an;
    logic [6:0]        r_seg;
    logic              r_dp;

    logic              w_slot_last;
    logic              w_frame_last;
    logic              w_blink_last;
    logic [3:0]        w_digit;
    logic [6:0]        w_dec_seg;
    logic [3:0]        w_an;
    logic [6:0]        w_seg;
    logic              w_dp;

    assign w_slot_last  = (r_slot_cnt == SlotLast);
    assign w_frame_last = w_slot_last && (r_idx == IDX_LAST);
    assign w_blink_last = (r_blink_cnt == BlinkLast);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_slot_cnt    <= '0;
            r_idx         <= '0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b1;
            r_digit_s     <= '0;
            r_blink_s     <= '0;
            r_dp_s        <= '0;
            r_blank_lz_s  <= 1'b0;
        end else begin
            r_slot_cnt  <= w_slot_last ? '0 : r_slot_cnt + SlotW'(1);
            if (w_slot_last) begin
                r_idx <= r_idx + IDX_W'(1);
            end
            r_blink_cnt <= w_blink_last ? '0 : r_blink_cnt + BlinkW'(1);
            if (w_blink_last) begin
                r_blink_phase <= ~r_blink_phase;
            end
            // Latch on the last cycle of slot 3 so the next frame is coherent.
            if (w_frame_last) begin
                r_digit_s    <= {bus.thousands, bus.hundreds, bus.tens, bus.ones};
                r_blink_s    <= bus.blink_mask;
                r_dp_s       <= bus.dp_mask;
                r_blank_lz_s <= bus.blank_lz;
            end
        end
    end

    assign w_digit = r_digit_s[r_idx];

    seg7_decode u_decode (
        .i_bcd (w_digit),
        .o_seg (w_dec_seg)
    );

    always_comb begin
        w_an  = AN_OFF;
        w_seg = SEG_BLANK;
        w_dp  = 1'b1;
        if (r_slot_cnt >= BlankCnt) begin
            w_an  = ~(4'b0001 << r_idx);
            w_dp  = ~r_dp_s[r_idx];
            w_seg = w_dec_seg;
            if ((r_blink_s[r_idx] && !r_blink_phase) ||
                ((r_idx == IDX_LAST) && r_blank_lz_s && (w_digit == 4'd0))) begin
                w_seg = SEG_BLANK;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_an  <= AN_OFF;
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= w_an;
            r_seg <= w_seg;
            r_dp  <= w_dp;
        end
    end

    assign bus.an  = r_an;
    assign bus.seg = r_seg;
    assign bus.dp  = r_dp;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench: each frame's lit-slot outputs are queued ahead of time and
// a monitor pops one entry per cycle with an anode low.
module tb_seg7_scan_driver;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   blank_run = 0;
    logic [11:0] exp_q[$];

    seg7_scan_driver_if bus ();

    seg7_scan_driver #(
        .SCAN_DIV  (8),
        .BLANK_CYC (2),
        .BLINK_DIV (64)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp_v, $time);
    endtask

    task automatic push_slot(input logic [3:0] an, input logic [6:0] seg, input logic dp,
                             input int n);
        repeat (n) exp_q.push_back({an, seg, dp});
    endtask

    task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                              input logic [6:0] s3, input logic [3:0] dpm);
        push_slot(4'b1110, s0, ~dpm[0], 6);
        push_slot(4'b1101, s1, ~dpm[1], 6);
        push_slot(4'b1011, s2, ~dpm[2], 6);
        push_slot(4'b0111, s3, ~dpm[3], 6);
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_digits(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2,
                              input logic [3:0] d3);
        bus.ones = d0; bus.tens = d1; bus.hundreds = d2; bus.thousands = d3;
    endtask

    // Monitor: sampled 1 time unit after each rising edge.
    initial begin
        logic [11:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                blank_run = 0;
            end else if (bus.an == 4'hF) begin
                blank_run++;
                check("blank_seg_dp", {25'd0, bus.seg, bus.dp}, {25'd0, 7'h7F, 1'b1});
            end else begin
                check("one_hot_anode",
                      32'((bus.an == 4'b1110) || (bus.an == 4'b1101) ||
                          (bus.an == 4'b1011) || (bus.an == 4'b0111)), 32'd1);
                if (blank_run != 0) check("blank_len", 32'(blank_run), 32'd2);
                blank_run = 0;
                if (exp_q.size() == 0) begin
                    check("unexpected_lit", {20'd0, bus.an, bus.seg, bus.dp}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("slot_out", {20'd0, bus.an, bus.seg, bus.dp}, {20'd0, e});
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        set_digits(4'd0, 4'd0, 4'd0, 4'd0);
        bus.blink_mask = 4'd0;
        bus.dp_mask    = 4'd0;
        bus.blank_lz   = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("reset_an", 32'(bus.an), 32'hF);
        check("reset_seg", 32'(bus.seg), 32'h7F);
        check("reset_dp", 32'(bus.dp), 32'h1);
        run(3);
        reset = 1'b0;

        // Frames 0,1: idle zeros; new digits set in frame 1 show from frame 2.
        push_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'b0000); run(32);
        push_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'b0000);
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        run(32);
        push_frame(7'h79, 7'h24, 7'h30, 7'h19, 4'b0000);
        bus.ones = 4'd5;
        run(32);
        // Change during slot 2 must not affect the current frame.
        push_frame(7'h12, 7'h24, 7'h30, 7'h19, 4'b0000);
        run(18);
        bus.ones = 4'd6;
        run(14);
        push_frame(7'h02, 7'h24, 7'h30, 7'h19, 4'b0000);
        set_digits(4'd7, 4'd7, 4'd7, 4'd7);
        bus.blink_mask = 4'b0011;
        run(32);
        // Blink phase: visible frames 0-1,4-5,8-9; hidden 2-3,6-7.
        push_frame(7'h78, 7'h78, 7'h78, 7'h78, 4'b0000); run(32);
        push_frame(7'h7F, 7'h7F, 7'h78, 7'h78, 4'b0000); run(32);
        push_frame(7'h7F, 7'h7F, 7'h78, 7'h78, 4'b0000); run(32);
        push_frame(7'h78, 7'h78, 7'h78, 7'h78, 4'b0000);
        bus.blink_mask = 4'b0000;
        bus.thousands  = 4'd0;
        bus.blank_lz   = 1'b1;
        bus.dp_mask    = 4'b1000;
        run(32);
        push_frame(7'h78, 7'h78, 7'h78, 7'h7F, 4'b1000);
        bus.blank_lz = 1'b0;
        run(32);
        push_frame(7'h78, 7'h78, 7'h78, 7'h40, 4'b1000); run(32);

        // Frame 11: reset mid slot 2 after two lit cycles.
        push_slot(4'b1110, 7'h78, 1'b1, 6);
        push_slot(4'b1101, 7'h78, 1'b1, 6);
        push_slot(4'b1011, 7'h78, 1'b1, 2);
        run(20);
        reset = 1'b1;
        #1;
        check("midreset_an", 32'(bus.an), 32'hF);
        check("midreset_seg", 32'(bus.seg), 32'h7F);
        check("midreset_dp", 32'(bus.dp), 32'h1);
        run(2);
        bus.ones = 4'd11;
        run(1);
        reset = 1'b0;

        push_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'b0000); run(32);
        push_frame(7'h7F, 7'h78, 7'h78, 7'h40, 4'b1000); run(32);
        run(1);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Consumes the four BCD digits (ones, tens, hundreds, thousands) produced by the time-to-digits stage and drives a 4-digit common-anode multiplexed 7-segment display.
- Time-multiplexes one digit per slot with a programmable refresh divider and an anti-ghosting blank interval.
- Provides per-digit blinking for set modes, decimal-point control and leading-zero blanking.
- Digit inputs are snapshotted once per full scan so a displayed frame never mixes old and new values.

Parameters:
- SCAN_DIV, 100000, clk cycles per digit slot (≥4).
- BLANK_CYC, 2000, cycles at the start of each slot with all anodes off (< SCAN_DIV).
- BLINK_DIV, 25000000, clk cycles per blink half-period (≥2).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- ones  in  4  BCD digit 0 (rightmost)
- tens  in  4  BCD digit 1
- hundreds  in  4  BCD digit 2
- thousands  in  4  BCD digit 3 (leftmost)
- blink_mask  in  4  bit i=1 → digit i blinks
- dp_mask  in  4  bit i=1 → decimal point of digit i lit
- blank_lz  in  1  1 → blank digit 3 when its snapshot value is 0
- an  out  4  anode enables, active-low, an[i] ↔ digit i
- seg  out  7  cathodes, active-low, seg[0]=a … seg[6]=g
- dp  out  1  decimal-point cathode, active-low

Behaviour:
- Reset (async, any time including mid-scan):
  - an=4'b1111, seg=7'h7F, dp=1.
  - slot_cnt=0, idx=0, blink_cnt=0, blink_phase=1 (visible).
  - Snapshot digits = 0.
- Slot counter:
  - slot_cnt counts 0..SCAN_DIV-1 and wraps to 0.
  - At terminal count, idx increments modulo 4 (0→1→2→3→0).
- Snapshot:
  - On the cycle where slot_cnt==SCAN_DIV-1 and idx==3, all four digit inputs, blink_mask, dp_mask and blank_lz are latched.
  - The latched values are used from slot 0 of the next frame onward.
  - Input changes on any other cycle have no effect on the current frame.
- Blink:
  - blink_cnt counts 0..BLINK_DIV-1.
  - At terminal count blink_phase toggles.
  - Free-running, independent of scan.
- Per-slot output, computed from the current slot_cnt/idx and registered (1-cycle latency):
  - slot_cnt < BLANK_CYC → an=1111, seg=7F, dp=1.
  - Otherwise an = ~(1<<idx). dp = ~dp_mask_s[idx].
  - seg = decode(digit_s[idx]), except seg=7F (digit off) when:
    - blink_mask_s[idx] && !blink_phase, or
    - idx==3 && blank_lz_s && digit_s[3]==0, or
    - digit_s[idx] > 9.
  - dp is not affected by blink or leading-zero blanking.
- Decode: standard active-low patterns.
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
  - 10–15 → 7'h7F.
- Exactly one anode is low, or none; never two.
- No handshake: the upstream stage drives its digit outputs continuously. Upstream register updates are tolerated at any cycle.

Decomposition:
- Shared package seg7_pkg:
  - Segment pattern constants SEG_0..SEG_9.
  - SEG_BLANK=7'h7F.
  - AN_OFF=4'hF.
  - Digit-index width constant.
- One combinational sub-module, seg7_decode: 4-bit BCD in, 7-bit active-low segments out, blank for >9.
- Counters, snapshot and output register stay in the top.

Test Plan:
All scenarios use SCAN_DIV=8, BLANK_CYC=2, BLINK_DIV=64.
- Reset then idle with all inputs 0, blink_mask=0, dp_mask=0:
  - an cycles 1110,1101,1011,0111, each low for 6 of every 8 cycles with 1111 between slots.
  - seg=7'h40 whenever an≠1111.
- Digits 1,2,3,4 (ones..thousands) applied after reset, held stable:
  - After the first frame wrap, slot 0 shows 7'h79, slot1 7'h24, slot2 7'h30, slot3 7'h19.
  - Before the wrap, all lit slots show 7'h40.
- Change ones 5→6 during slot 2 of a frame:
  - Slot 3 of that frame and the frame remainder are unchanged.
  - The next frame's slot 0 shows 7'h02.
- blink_mask=4'b0011 with digits 7,7,7,7:
  - Digits 0,1 alternate 7'h78 / 7'h7F every 64 cycles while their anode is low.
  - Digits 2,3 are steadily 7'h78.
- blank_lz=1, thousands=0, dp_mask=4'b1000:
  - Slot 3 shows seg=7'h7F, dp=0, an=0111.
  - With blank_lz=0, slot 3 shows 7'h40.
- Assert reset mid-slot 2, then ones=11:
  - Outputs go to 1111/7F/1 immediately.
  - After release, scan restarts at idx 0 and shows 7'h40.
  - After the next wrap, slot 0 shows 7'h7F.
